// File: rtl/lbus_pkg.sv
// Shared local-bus definitions: command bytes, well-known slave addresses and
// the host-master FSM state encoding.
package lbus_pkg;
  localparam logic [7:0]  LBUS_CMD_READ      = 8'h00;
  localparam logic [7:0]  LBUS_CMD_WRITE     = 8'h01;
  localparam logic [15:0] LBUS_ADDR_CTRL     = 16'h0002;
  localparam logic [15:0] LBUS_ADDR_START    = 16'h3000;
  localparam logic [15:0] LBUS_ADDR_OPR_BASE = 16'h4000;
  localparam int          LBUS_TMR_W         = 16;

  typedef enum logic [3:0] {
    ST_IDLE, ST_CMD, ST_AH, ST_AL, ST_DH, ST_DL,
    ST_RWAIT, ST_RH, ST_RL, ST_DONE
  } lbus_state_e;
endpackage

// File: rtl/lbus_strobe_timer.sv
// Loadable down-counter shared by the strobe-gap, read-latency and RWAIT
// timeout phases; done is high while the count sits at zero.
module lbus_strobe_timer
  import lbus_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [LBUS_TMR_W-1:0] load_val,
  output logic                  done
);
  logic [LBUS_TMR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign done = (cnt_q == '0);
endmodule

// File: rtl/lbus_host_master.sv
// Host-side SAKURA-G local bus initiator: one 16-bit request becomes a byte
// sequence on HWE/HDIN (and HRE/HDOUT for reads). Optional RWAIT timeout: LBUS_MASTER_TIMEOUT_EN.
module lbus_host_master
  import lbus_pkg::*;
#(
  parameter int WR_GAP      = 1,
  parameter int RD_LAT      = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  input  logic        DEVRDY,
  input  logic        RRDYn,
  input  logic        WRDYn,
  output logic        HWE,
  output logic [7:0]  HDIN,
  output logic        HRE,
  input  logic [7:0]  HDOUT
);
  // A byte state lasts one strobe cycle plus WR_GAP gap cycles; HDOUT is
  // sampled on the RD_LAT-th edge after the HRE strobe edge.
  localparam logic [LBUS_TMR_W-1:0] GAP_LD = LBUS_TMR_W'(WR_GAP);
  localparam logic [LBUS_TMR_W-1:0] LAT_LD = LBUS_TMR_W'(RD_LAT - 1);
`ifdef LBUS_MASTER_TIMEOUT_EN
  localparam logic [LBUS_TMR_W-1:0] TO_LD  = LBUS_TMR_W'(TIMEOUT_CYC - 1);
  logic rsp_err_q, rsp_err_d;
`endif

  lbus_state_e state_q, state_d;
  logic        write_q, write_d;
  logic [15:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [7:0]  rdata_hi_q, rdata_hi_d;
  logic        seen_q, seen_d;
  logic        hwe_q, hwe_d, hre_q, hre_d;
  logic [7:0]  hdin_q, hdin_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_rdata_q, rsp_rdata_d;
  logic                  tmr_load, tmr_done;
  logic [LBUS_TMR_W-1:0] tmr_val;

  lbus_strobe_timer u_timer (
    .clk      (CLK),
    .rst_n    (RSTn),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Readiness of the slave is only qualified while idle.
  assign req_ready = RSTn && (state_q == ST_IDLE) && DEVRDY && !WRDYn;

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_hi_d  = rdata_hi_q;
    seen_d      = seen_q;
    hwe_d       = 1'b0;
    hre_d       = 1'b0;
    hdin_d      = hdin_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    tmr_load    = 1'b0;
    tmr_val     = GAP_LD;
`ifdef LBUS_MASTER_TIMEOUT_EN
    rsp_err_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: if (req_valid && req_ready) begin
        write_d  = req_write;
        addr_d   = req_addr;
        wdata_d  = req_wdata;
        state_d  = ST_CMD;
        hwe_d    = 1'b1;
        hdin_d   = req_write ? LBUS_CMD_WRITE : LBUS_CMD_READ;
        tmr_load = 1'b1;
      end
      ST_CMD: if (tmr_done) begin
        state_d = ST_AH; hwe_d = 1'b1; hdin_d = addr_q[15:8]; tmr_load = 1'b1;
      end
      ST_AH: if (tmr_done) begin
        state_d = ST_AL; hwe_d = 1'b1; hdin_d = addr_q[7:0]; tmr_load = 1'b1;
      end
      ST_AL: if (tmr_done) begin
        if (write_q) begin
          state_d = ST_DH; hwe_d = 1'b1; hdin_d = wdata_q[15:8]; tmr_load = 1'b1;
        end else begin
          state_d = ST_RWAIT;
          seen_d  = 1'b0;
`ifdef LBUS_MASTER_TIMEOUT_EN
          tmr_load = 1'b1;
          tmr_val  = TO_LD;
`endif
        end
      end
      ST_DH: if (tmr_done) begin
        state_d = ST_DL; hwe_d = 1'b1; hdin_d = wdata_q[7:0]; tmr_load = 1'b1;
      end
      ST_DL: if (tmr_done) begin
        state_d = ST_DONE; rsp_valid_d = 1'b1;
      end
      ST_RWAIT: begin
        // seen_q remembers that RRDYn was low on the previous edge.
        seen_d = !RRDYn;
        if (!RRDYn && seen_q) begin
          state_d = ST_RH; hre_d = 1'b1; tmr_load = 1'b1; tmr_val = LAT_LD;
        end
`ifdef LBUS_MASTER_TIMEOUT_EN
        else if (tmr_done) begin
          state_d     = ST_DONE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = 16'hDEAD;
          rsp_err_d   = 1'b1;
        end
`endif
      end
      ST_RH: if (tmr_done) begin
        rdata_hi_d = HDOUT;
        state_d = ST_RL; hre_d = 1'b1; tmr_load = 1'b1; tmr_val = LAT_LD;
      end
      ST_RL: if (tmr_done) begin
        state_d = ST_DONE; rsp_valid_d = 1'b1; rsp_rdata_d = {rdata_hi_q, HDOUT};
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= ST_IDLE;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_hi_q  <= '0;
      seen_q      <= 1'b0;
      hwe_q       <= 1'b0;
      hre_q       <= 1'b0;
      hdin_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef LBUS_MASTER_TIMEOUT_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_hi_q  <= rdata_hi_d;
      seen_q      <= seen_d;
      hwe_q       <= hwe_d;
      hre_q       <= hre_d;
      hdin_q      <= hdin_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef LBUS_MASTER_TIMEOUT_EN
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign HWE       = hwe_q;
  assign HRE       = hre_q;
  assign HDIN      = hdin_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
`ifdef LBUS_MASTER_TIMEOUT_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif
endmodule

// File: tb/tb_lbus_host_master.sv
// Self-checking bench for lbus_host_master: directed and randomized requests
// against a byte-sequence/transaction-level model and a simple slave.
module tb_lbus_host_master;
  localparam int WR_GAP = 1;
  localparam int RD_LAT = 2;
`ifdef LBUS_MASTER_TIMEOUT_EN
  localparam int TO_CYC = 16;
  localparam int MAX_RR = 8;
`else
  localparam int TO_CYC = 1024;
  localparam int MAX_RR = 60;
`endif

  logic        CLK = 1'b0, RSTn = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, HWE, HRE;
  logic [15:0] rsp_rdata;
  logic [7:0]  HDIN;
  logic        DEVRDY = 1'b1, RRDYn = 1'b1, WRDYn = 1'b0;
  logic [7:0]  HDOUT = 8'h00;

  always #5 CLK = ~CLK;

  lbus_host_master #(.WR_GAP(WR_GAP), .RD_LAT(RD_LAT), .TIMEOUT_CYC(TO_CYC)) dut (
    .CLK(CLK), .RSTn(RSTn), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .DEVRDY(DEVRDY), .RRDYn(RRDYn), .WRDYn(WRDYn),
    .HWE(HWE), .HDIN(HDIN), .HRE(HRE), .HDOUT(HDOUT)
  );

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Edge counter and run length of RRDYn low as sampled on rising edges.
  int cyc = 0, rr_run = 0;
  initial forever begin
    @(posedge CLK);
    cyc = cyc + 1;
    rr_run = RRDYn ? 0 : ((rr_run < 3) ? rr_run + 1 : rr_run);
  end

  // Bus monitor and slave: records strobes/responses, drives HDOUT only in
  // the single cycle the master is due to sample it.
  logic [7:0]  hwe_b[$];
  int          hwe_c[$];
  int          hre_cnt = 0, overlap = 0, early = 0, rsp_cnt = 0, rsp_cyc = 0;
  int          hre_cyc = -100;
  logic [15:0] rsp_rd = '0, slave_data = '0;
  logic        rsp_er = 1'b0;
  initial forever begin
    @(negedge CLK);
    if (HWE) begin hwe_b.push_back(HDIN); hwe_c.push_back(cyc); end
    if (HRE) begin
      hre_cnt++;
      hre_cyc = cyc;
      if (rr_run < 2) early++;
    end
    if (HRE && HWE) overlap++;
    if (rsp_valid) begin rsp_cnt++; rsp_cyc = cyc; rsp_rd = rsp_rdata; rsp_er = rsp_err; end
    if (cyc == hre_cyc + RD_LAT - 1)
      HDOUT = hre_cnt[0] ? slave_data[15:8] : slave_data[7:0];
    else
      HDOUT = 8'($urandom);
  end

  task automatic run_txn(input bit wr, input logic [15:0] a, input logic [15:0] d,
                         input logic [15:0] rd, input int rr_dly, input bit noisy);
    int hb, hrb, ob, eb, rb, acc, k;
    logic [7:0] exp_b[$];
    logic prev_low;
    hb = hwe_b.size(); hrb = hre_cnt; ob = overlap; eb = early; rb = rsp_cnt;
    exp_b.push_back(wr ? 8'h01 : 8'h00);
    exp_b.push_back(a[15:8]);
    exp_b.push_back(a[7:0]);
    if (wr) begin exp_b.push_back(d[15:8]); exp_b.push_back(d[7:0]); end
    slave_data = rd;
    @(negedge CLK);
    DEVRDY = 1'b1; WRDYn = 1'b0;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    #1;
    k = 0;
    while (!req_ready && k < 100) begin @(negedge CLK); #1; k++; end
    chk("req_ready_wait", k, 0);
    acc = cyc;
    @(posedge CLK); #1;
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = 16'($urandom); req_wdata = 16'($urandom);
    if (!wr) begin
      k = 0;
      while (hwe_b.size() < hb + 3 && k < 200) begin @(negedge CLK); k++; end
      prev_low = 1'b0;
      for (int i = 0; i < rr_dly; i++) begin
        @(negedge CLK);
        if (noisy) begin
          RRDYn = prev_low ? 1'b1 : ($urandom_range(0, 2) != 0);
          DEVRDY = 1'($urandom);
        end
        prev_low = !RRDYn;
      end
      @(negedge CLK);
      RRDYn = 1'b0;
    end
    k = 0;
    while (rsp_cnt == rb && k < 4000) begin @(negedge CLK); k++; end
    repeat (2) @(negedge CLK);
    RRDYn = 1'b1; DEVRDY = 1'b1;
    chk("rsp_count", rsp_cnt - rb, 1);
    chk("hwe_count", hwe_b.size() - hb, exp_b.size());
    for (int i = 0; i < exp_b.size(); i++)
      chk("hwe_byte", (hb + i < hwe_b.size()) ? {24'h0, hwe_b[hb + i]} : 'x, {24'h0, exp_b[i]});
    for (int i = 1; i < exp_b.size(); i++)
      chk("hwe_gap", (hb + i < hwe_c.size()) ? hwe_c[hb + i] - hwe_c[hb + i - 1] : 'x, 1 + WR_GAP);
    if (wr) chk("wr_latency", rsp_cyc - acc, 5 * (1 + WR_GAP) + 1);
    chk("rsp_rdata", rsp_rd, wr ? 16'h0000 : rd);
    chk("rsp_err", rsp_er, 0);
    chk("hre_count", hre_cnt - hrb, wr ? 0 : 2);
    chk("hre_hwe_overlap", overlap - ob, 0);
    chk("hre_before_rrdy", early - eb, 0);
  endtask

  initial begin
    int hb, rb, hrb, k;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_hwe", HWE, 0);
    chk("rst_hre", HRE, 0);
    chk("rst_hdin", HDIN, 8'h00);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 16'h0000);
    chk("rst_rsp_err", rsp_err, 0);
    repeat (3) @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);

    run_txn(1'b1, 16'h4102, 16'hBEEF, 16'h0000, 0, 1'b0);
    run_txn(1'b0, 16'h4000, 16'h0000, 16'h1234, 3, 1'b0);

    // Slave not ready / write-busy: request must be held off.
    for (int m = 0; m < 2; m++) begin
      hb = hwe_b.size();
      @(negedge CLK);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h3000; req_wdata = 16'h0001;
      if (m == 0) DEVRDY = 1'b0; else WRDYn = 1'b1;
      for (int i = 0; i < 6; i++) begin
        @(negedge CLK); #1;
        chk("blocked_ready", req_ready, 0);
      end
      chk("blocked_hwe", hwe_b.size() - hb, 0);
      run_txn(m == 0, 16'h0002, 16'h00A5, 16'h5A5A, 2, 1'b0);
    end

`ifndef LBUS_MASTER_TIMEOUT_EN
    run_txn(1'b0, 16'h4123, 16'h0000, 16'hA5C3, 50, 1'b0);
`endif

    for (int t = 0; t < 20; t++)
      run_txn(1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
              $urandom_range(0, MAX_RR), 1'($urandom));

    // Reset pulse after the address-high byte abandons the write.
    hb = hwe_b.size(); rb = rsp_cnt;
    @(negedge CLK);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h7E10; req_wdata = 16'hC0DE;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    k = 0;
    while (hwe_b.size() < hb + 2 && k < 100) begin @(negedge CLK); k++; end
    @(negedge CLK);
    RSTn = 1'b0;
    #1;
    chk("midrst_hwe", HWE, 0);
    chk("midrst_hre", HRE, 0);
    chk("midrst_hdin", HDIN, 8'h00);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_req_ready", req_ready, 0);
    repeat (3) @(negedge CLK);
    RSTn = 1'b1;
    repeat (20) @(negedge CLK);
    chk("midrst_no_rsp", rsp_cnt - rb, 0);
    chk("midrst_hwe_count", hwe_b.size() - hb, 2);
    run_txn(1'b1, 16'h0002, 16'h0001, 16'h0000, 0, 1'b0);

`ifdef LBUS_MASTER_TIMEOUT_EN
    // RRDYn stuck high: the read must time out without any HRE.
    hrb = hre_cnt; rb = rsp_cnt;
    @(negedge CLK);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h4000;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    k = 0;
    while (rsp_cnt == rb && k < 500) begin @(negedge CLK); k++; end
    repeat (2) @(negedge CLK);
    chk("to_rsp_count", rsp_cnt - rb, 1);
    chk("to_rsp_err", rsp_er, 1);
    chk("to_rsp_rdata", rsp_rd, 16'hDEAD);
    chk("to_hre_count", hre_cnt - hrb, 0);
`else
    hrb = 0;
    if (hrb != 0) $display("unreachable");
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
